// File: rtl/uart_stream_tx.sv
// uart_stream_tx: serializes BYTES_PER_BEAT bytes of each 64-bit stream beat onto an 8N1 UART line, LSB byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (11-bit frames).
module uart_stream_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int BYTES_PER_BEAT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_s_axis_tdata,
    input  logic        i_s_axis_tvalid,
    input  logic        i_s_axis_tlast,
    output logic        o_s_axis_tready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_byte_done,
    output logic        o_pkt_done
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_BEAT - 1);

    generate
        if (BAUD_DIV < 2) begin : g_bad_baud
            $error("uart_stream_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (BYTES_PER_BEAT < 1 || BYTES_PER_BEAT > 8) begin : g_bad_bytes
            $error("uart_stream_tx: BYTES_PER_BEAT must be within 1..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [63:0]   sh_q, sh_d;
    logic          last_q, last_d;
    logic          tx_q, tx_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          byte_done_q, byte_done_d;
    logic          pkt_done_q, pkt_done_d;
    logic          tick;
    logic [7:0]    cur;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        last_d  = last_q;
        tick    = (cnt_q == BAUD_MAX);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_s_axis_tvalid && rdy_q) begin
                    sh_d    = i_s_axis_tdata;
                    last_d  = i_s_axis_tlast;
                    byte_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                    end else begin
                        sh_d    = sh_q >> 8;
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are registered from next-state so they line up with the state they describe
        cur  = sh_d[7:0];
        tx_d = (state_d == S_START) ? 1'b0 :
               (state_d == S_DATA)  ? cur[bit_d] :
`ifdef UART_TX_PARITY_EN
               (state_d == S_PARITY) ? ^cur :
`endif
               1'b1;
        rdy_d       = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        byte_done_d = (state_d == S_STOP) && (cnt_d == BAUD_MAX);
        pkt_done_d  = byte_done_d && (byte_d == LAST_BYTE) && last_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            sh_q        <= '0;
            last_q      <= 1'b0;
            tx_q        <= 1'b1;
            rdy_q       <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sh_q        <= sh_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    assign o_s_axis_tready = rdy_q;
    assign o_tx            = tx_q;
    assign o_busy          = busy_q;
    assign o_byte_done     = byte_done_q;
    assign o_pkt_done      = pkt_done_q;
endmodule

// File: doc/uart_stream_tx.md
Name: uart_stream_tx

Overview:
AXI-Stream to UART serializer; the transmit counterpart of the uart_rx → stream_adapter ingress path. It accepts 64-bit stream beats and sends BYTES_PER_BEAT bytes of each beat on a single TX line, LSB byte first. This is the byte order stream_adapter uses to pack received bytes, so a beat sent here is rebuilt unchanged by a remote receiver. It sits on the system clock, times its own baud internally and reports progress to the host (state echo, score telemetry).

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
BYTES_PER_BEAT, 8, bytes sent per accepted beat (legal range 1..8); sent from tdata[7:0] upward

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_s_axis_tdata  in  64  beat payload; bits at or above 8*BYTES_PER_BEAT are ignored
i_s_axis_tvalid  in  1  beat valid
i_s_axis_tlast  in  1  last beat of packet
o_s_axis_tready  out  1  block can accept a beat
o_tx  out  1  UART serial output, idle high
o_busy  out  1  a beat is being serialized
o_byte_done  out  1  one-cycle pulse at the end of each stop bit
o_pkt_done  out  1  one-cycle pulse after the final byte of a beat that had tlast=1

Behaviour:
- Derived constant: BAUD_DIV = CLK_FREQ/BAUD_RATE, integer truncation; must be ≥2, otherwise elaboration error. Default value is 868.
- Reset values: o_tx=1, o_s_axis_tready=1, o_busy=0, o_byte_done=0, o_pkt_done=0. FSM=IDLE; baud counter, bit index and byte index all 0.
- Asserting reset mid-frame aborts immediately: o_tx returns to 1 asynchronously and the partial byte is discarded.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP (PARITY is added by the optional feature).
- IDLE:
  - o_s_axis_tready=1, o_busy=0, o_tx=1.
  - Handshake occurs when tvalid && tready at a clock edge. On that edge: latch tdata into a 64-bit shift register, latch tlast, set byte_idx=0, clear baud counter, go to START.
  - tready drops on the same edge. o_tx falls to 0 on the cycle after the handshake edge (latency 1).
- START: o_tx=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
- DATA:
  - o_tx = current byte bit[bit_idx], LSB first, each bit held BAUD_DIV cycles.
  - After bit 7, go to STOP.
- STOP:
  - o_tx=1 for BAUD_DIV cycles.
  - On the final cycle, pulse o_byte_done, then:
    - if byte_idx==BYTES_PER_BEAT-1: go to IDLE; pulse o_pkt_done in the same cycle if the latched tlast=1;
    - else: shift register right by 8, byte_idx+1, go to START.
- Baud counter: counts 0..BAUD_DIV-1 and restarts at every bit boundary. No drift accumulates across bytes.
- Frame length: 10*BAUD_DIV cycles per byte. Bytes within a beat are back-to-back with no gap between bytes.
- Back-to-back beats:
  - tready re-asserts on the cycle IDLE is entered.
  - If tvalid is held high, the next beat is accepted on that first IDLE cycle, giving an inter-beat idle-high gap of exactly 1 cycle.
- Input changes while busy: tvalid and tdata changes have no effect on the beat in flight. Without a handshake nothing is latched.
- o_busy = (state != IDLE).

Optional Feature:
UART_TX_PARITY_EN:
- Defined: PARITY state inserted between DATA and STOP. o_tx = XOR of the 8 data bits (even parity), held BAUD_DIV cycles. Frame becomes 11*BAUD_DIV cycles.
- Undefined: no PARITY state; 10-bit frames exactly as described above.

Test Plan:
All cases use CLK_FREQ=1000, BAUD_RATE=100 (BAUD_DIV=10) unless noted.
1. Reset, then 5 idle cycles → o_tx=1, tready=1, busy=0, no pulses. Assert reset mid-DATA → o_tx=1 and tready=1 within the reset cycle.
2. BYTES_PER_BEAT=2, single beat tdata=64'h0955, tlast=1 → o_tx sequence per 10 cycles:
   - byte 0x55: 0,1,0,1,0,1,0,1,0,1
   - byte 0x09: 0,1,0,0,1,0,0,0,0,1
   - o_byte_done pulses at cycles 100 and 200 after the handshake; o_pkt_done coincides with the second; tready=1 at cycle 201.
3. Two beats with tvalid held high, tdata=64'hA5 then 64'h3C, BYTES_PER_BEAT=1 → second handshake on the first cycle tready returns; o_tx high for exactly 1 cycle between frames; frames decode as 0xA5 then 0x3C.
4. While busy, toggle tvalid and change tdata every cycle → the frame in flight is unchanged; no extra beat is accepted until IDLE.
5. Default CLK_FREQ/BAUD_RATE with a loopback through clk_divider + uart_rx + stream_adapter, send 64'h0123456789ABCDEF → adapter output tdata equals the sent value; each bit lasts 868 cycles.
6. UART_TX_PARITY_EN defined, byte 0x07 → parity bit 1, frame 110 cycles. Byte 0x03 → parity bit 0.
